// File: rtl/udp_rx_parser.sv
// UDP receive parser: filters Ethernet/IPv4/UDP headers from the 10G MAC RX stream
// and writes the re-aligned payload into the user RX FIFO.
module udp_rx_parser #(
  parameter logic [47:0] LOCAL_MAC  = 48'h00_1C_23_17_4A_CB,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0002,
  parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
  input  logic        clk_156_25,
  input  logic        rst,
  input  logic        avalon_st_rx_startofpacket,
  input  logic        avalon_st_rx_endofpacket,
  input  logic        avalon_st_rx_valid,
  output logic        avalon_st_rx_ready,
  input  logic [63:0] avalon_st_rx_data,
  input  logic [2:0]  avalon_st_rx_empty,
  input  logic [5:0]  avalon_st_rx_error,
  output logic [63:0] wr_data,
  output logic        wr_req,
  output logic        rx_finish,
  output logic        rx_drop,
  output logic [15:0] rx_length
);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, FLUSH, DROP} state_t;

  state_t      state, state_nx;
  logic [2:0]  beat, beat_nx, hdr_beat;
  logic [15:0] bytes_left, bytes_left_nx, len, len_nx, take, bl_after, rx_length_nx;
  logic [47:0] hold, hold_nx;
  logic        first, first_nx, err, err_nx;
  logic [63:0] wr_data_nx, d;
  logic        wr_req_nx, rx_finish_nx, rx_drop_nx;
  logic        acc, sop, eop, hdr_pass, wr_now, bad_eop;
  logic        unused_empty;

  assign unused_empty = ^avalon_st_rx_empty;
  assign d        = avalon_st_rx_data;
  assign sop      = avalon_st_rx_startofpacket;
  assign eop      = avalon_st_rx_endofpacket;
  assign acc      = avalon_st_rx_valid && avalon_st_rx_ready;
  assign hdr_beat = sop ? 3'd0 : beat;
  assign bad_eop  = |avalon_st_rx_error;

  // Keep the first n bytes of a word (n >= 8 keeps all of it)
  function automatic logic [63:0] keep_mask(input logic [15:0] n);
    if (n >= 16'd8) return {64{1'b1}};
    return ~({64{1'b1}} >> {n[2:0], 3'b000});
  endfunction

  // Per-beat header filter; a frame survives only if every header beat passes
  always_comb begin
    hdr_pass = 1'b0;
    case (hdr_beat)
      3'd0: hdr_pass = (d[63:16] == LOCAL_MAC) || (d[63:16] == {48{1'b1}});
      3'd1: hdr_pass = (d[31:16] == 16'h0800) && (d[15:8] == 8'h45);
      3'd2: hdr_pass = (d[7:0] == 8'd17);
      3'd3: hdr_pass = (d[15:0] == LOCAL_IP[31:16]);
      3'd4: hdr_pass = (d[63:48] == LOCAL_IP[15:0]) && (d[31:16] == LOCAL_PORT) &&
                       (d[15:0] >= 16'd8);
      default: hdr_pass = 1'b0;
    endcase
  end

  // Payload byte accounting for the current beat
  always_comb begin
    take     = (bytes_left > 16'd8) ? 16'd8 : bytes_left;
    wr_now   = !first && (bytes_left != 16'd0);
    bl_after = wr_now ? (bytes_left - take) : bytes_left;
  end

  always_ff @(posedge clk_156_25) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == FLUSH) begin
      state_nx = IDLE;
    end else if (acc) begin
      if (sop) begin
        state_nx = eop ? IDLE : (hdr_pass ? HDR : DROP);
      end else begin
        case (state)
          HDR: begin
            if (eop)                state_nx = IDLE;
            else if (!hdr_pass)     state_nx = DROP;
            else if (beat == 3'd4)  state_nx = PAYLOAD;
          end
          PAYLOAD: begin
            if (eop) state_nx = (bl_after != 16'd0 && bl_after <= 16'd6) ? FLUSH : IDLE;
          end
          DROP:    if (eop) state_nx = IDLE;
          default: state_nx = state;
        endcase
      end
    end
  end

  always_comb begin
    wr_req_nx     = 1'b0;
    rx_finish_nx  = 1'b0;
    rx_drop_nx    = 1'b0;
    wr_data_nx    = wr_data;
    rx_length_nx  = rx_length;
    beat_nx       = beat;
    bytes_left_nx = bytes_left;
    len_nx        = len;
    hold_nx       = hold;
    first_nx      = first;
    err_nx        = err;
    if (state == FLUSH) begin
      wr_req_nx  = 1'b1;
      wr_data_nx = {hold, 16'h0000} & keep_mask(bytes_left);
      if (err) begin
        rx_drop_nx = 1'b1;
      end else begin
        rx_finish_nx = 1'b1;
        rx_length_nx = len;
      end
    end else if (acc) begin
      if (sop) begin
        beat_nx    = 3'd1;
        rx_drop_nx = eop;
      end else begin
        case (state)
          HDR: begin
            beat_nx    = beat + 3'd1;
            rx_drop_nx = eop;
            if (beat == 3'd4) begin
              len_nx        = d[15:0] - 16'd8;
              bytes_left_nx = d[15:0] - 16'd8;
              first_nx      = 1'b1;
            end
          end
          PAYLOAD: begin
            first_nx      = 1'b0;
            hold_nx       = d[47:0];
            bytes_left_nx = bl_after;
            if (wr_now) begin
              wr_req_nx  = 1'b1;
              wr_data_nx = {hold, d[63:48]} & keep_mask(bytes_left);
            end
            if (eop) begin
              err_nx = bad_eop;
              if (bl_after == 16'd0 && !bad_eop) begin
                rx_finish_nx = 1'b1;
                rx_length_nx = len;
              end else if (bl_after == 16'd0 || bl_after > 16'd6) begin
                rx_drop_nx = 1'b1;
              end
            end
          end
          DROP:    rx_drop_nx = eop;
          default: rx_drop_nx = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_156_25) begin
    if (rst) begin
      avalon_st_rx_ready <= 1'b1;
      wr_data    <= '0;
      wr_req     <= 1'b0;
      rx_finish  <= 1'b0;
      rx_drop    <= 1'b0;
      rx_length  <= '0;
      beat       <= '0;
      bytes_left <= '0;
      len        <= '0;
      hold       <= '0;
      first      <= 1'b0;
      err        <= 1'b0;
    end else begin
      avalon_st_rx_ready <= (state_nx != FLUSH);
      wr_data    <= wr_data_nx;
      wr_req     <= wr_req_nx;
      rx_finish  <= rx_finish_nx;
      rx_drop    <= rx_drop_nx;
      rx_length  <= rx_length_nx;
      beat       <= beat_nx;
      bytes_left <= bytes_left_nx;
      len        <= len_nx;
      hold       <= hold_nx;
      first      <= first_nx;
      err        <= err_nx;
    end
  end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Directed bench for udp_rx_parser: builds frames byte by byte and checks FIFO writes and pulses.
`timescale 1ns/1ps
module tb_udp_rx_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sop = 1'b0, eop = 1'b0, valid = 1'b0, ready;
  logic [63:0] data = '0;
  logic [2:0]  empty = '0;
  logic [5:0]  error = '0;
  logic [63:0] wr_data;
  logic        wr_req, rx_finish, rx_drop;
  logic [15:0] rx_length;

  udp_rx_parser dut (
    .clk_156_25(clk), .rst(rst),
    .avalon_st_rx_startofpacket(sop), .avalon_st_rx_endofpacket(eop),
    .avalon_st_rx_valid(valid), .avalon_st_rx_ready(ready),
    .avalon_st_rx_data(data), .avalon_st_rx_empty(empty), .avalon_st_rx_error(error),
    .wr_data(wr_data), .wr_req(wr_req), .rx_finish(rx_finish), .rx_drop(rx_drop),
    .rx_length(rx_length)
  );

  always #3 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0]  fb[$];
  logic [63:0] words [0:255];
  logic [15:0] lens  [0:63];
  int wcnt = 0, fin_cnt = 0, drop_cnt = 0, fin_wr_cnt = 0;
  int wbase = 0, fbase = 0, dbase = 0, fwbase = 0;

  // Output monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (wr_req && wcnt < 256) begin words[wcnt] = wr_data; wcnt++; end
    if (rx_finish && fin_cnt < 64) begin lens[fin_cnt] = rx_length; fin_cnt++; end
    if (rx_finish && wr_req) fin_wr_cnt++;
    if (rx_drop) drop_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [47:0] mac, input logic [7:0] proto, input logic [31:0] ip,
                       input logic [15:0] port, input int plen, input logic [7:0] base,
                       input int minlen);
    logic [15:0] tl, ul;
    tl = 16'(plen + 28);
    ul = 16'(plen + 8);
    fb.delete();
    for (int i = 0; i < 6; i++) fb.push_back(mac[47-8*i -: 8]);
    fb.push_back(8'h02); fb.push_back(8'h00); fb.push_back(8'h00);
    fb.push_back(8'h00); fb.push_back(8'h00); fb.push_back(8'h01);
    fb.push_back(8'h08); fb.push_back(8'h00); fb.push_back(8'h45); fb.push_back(8'h00);
    fb.push_back(tl[15:8]); fb.push_back(tl[7:0]);
    for (int i = 0; i < 4; i++) fb.push_back(8'h00);
    fb.push_back(8'h40); fb.push_back(proto); fb.push_back(8'h00); fb.push_back(8'h00);
    fb.push_back(8'hC0); fb.push_back(8'hA8); fb.push_back(8'h00); fb.push_back(8'h01);
    for (int i = 0; i < 4; i++) fb.push_back(ip[31-8*i -: 8]);
    fb.push_back(8'h04); fb.push_back(8'hD2);
    fb.push_back(port[15:8]); fb.push_back(port[7:0]);
    fb.push_back(ul[15:8]); fb.push_back(ul[7:0]);
    fb.push_back(8'h00); fb.push_back(8'h00);
    for (int i = 0; i < plen; i++) fb.push_back(8'(base + 8'(i)));
    while (fb.size() < minlen) fb.push_back(8'h00);
  endtask

  task automatic drive_beat(input int b, input bit last, input logic [5:0] err, input bit rpulse);
    int n;
    @(negedge clk);
    rst   = rpulse;
    valid = 1'b1;
    sop   = (b == 0);
    eop   = last;
    error = last ? err : 6'd0;
    for (int k = 0; k < 8; k++)
      data[63-8*k -: 8] = (8*b + k < fb.size()) ? fb[8*b + k] : 8'h00;
    n = 0;
    while (!ready && n < 16) begin @(negedge clk); n++; end
    if (n >= 16) check("ready_timeout", 64'(ready), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rst = 1'b0; valid = 1'b0; sop = 1'b0; eop = 1'b0; error = '0;
    end
  endtask

  task automatic send(input int nb, input logic [5:0] err, input int gap_after);
    int cnt;
    cnt = (nb == 0) ? (fb.size() + 7) / 8 : nb;
    for (int b = 0; b < cnt; b++) begin
      drive_beat(b, b == cnt - 1, err, 1'b0);
      if (b == gap_after) idle(2);
    end
  endtask

  task automatic expect_frame(input string tag, input int nw, input logic [63:0] w0,
                              input logic [63:0] w1, input logic [63:0] w2, input int nfin,
                              input int ndrop, input int nfinwr, input int len);
    logic [63:0] ew;
    idle(8);
    check({tag, "_nwr"}, 64'(wcnt - wbase), 64'(nw));
    for (int i = 0; i < nw && i < 3 && wbase + i < wcnt; i++) begin
      ew = (i == 0) ? w0 : (i == 1) ? w1 : w2;
      check($sformatf("%s_w%0d", tag, i), words[wbase + i], ew);
    end
    check({tag, "_fin"},   64'(fin_cnt - fbase), 64'(nfin));
    check({tag, "_drop"},  64'(drop_cnt - dbase), 64'(ndrop));
    check({tag, "_align"}, 64'(fin_wr_cnt - fwbase), 64'(nfinwr));
    if (nfin > 0 && fin_cnt > 0) check({tag, "_len"}, 64'(lens[fin_cnt - 1]), 64'(len));
    wbase = wcnt; fbase = fin_cnt; dbase = drop_cnt; fwbase = fin_wr_cnt;
  endtask

  localparam logic [47:0] MAC = 48'h00_1C_23_17_4A_CB;
  localparam logic [47:0] BC  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] IP  = 32'hC0A8_0002;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    idle(1);
    check("rst_ready2", 64'(ready), 64'd1);
    check("rst_wr_req", 64'(wr_req), 64'd0);
    check("rst_finish", 64'(rx_finish), 64'd0);
    check("rst_drop", 64'(rx_drop), 64'd0);
    check("rst_len", 64'(rx_length), 64'd0);
    check("rst_wr_data", wr_data, 64'd0);

    build(MAC, 8'd17, IP, 16'd8080, 16, 8'h00, 60);
    send(0, 6'd0, -1);
    expect_frame("l16", 2, 64'h0001020304050607, 64'h08090A0B0C0D0E0F, 0, 1, 0, 1, 16);

    build(MAC, 8'd17, IP, 16'd8080, 10, 8'hA0, 60);
    send(0, 6'd0, -1);
    expect_frame("l10", 2, 64'hA0A1A2A3A4A5A6A7, 64'hA8A9000000000000, 0, 1, 0, 1, 10);
    check("len_hold", 64'(rx_length), 64'd10);

    build(MAC, 8'd17, IP, 16'd8081, 16, 8'h00, 60);
    send(0, 6'd0, -1);
    expect_frame("port", 0, 0, 0, 0, 0, 1, 0, 0);

    build(MAC, 8'd6, IP, 16'd8080, 16, 8'h00, 60);
    send(0, 6'd0, -1);
    expect_frame("proto", 0, 0, 0, 0, 0, 1, 0, 0);

    build(MAC, 8'd17, 32'hC0A8_0003, 16'd8080, 16, 8'h00, 60);
    send(0, 6'd0, -1);
    expect_frame("ip", 0, 0, 0, 0, 0, 1, 0, 0);

    build(MAC, 8'd17, IP, 16'd8080, 16, 8'h00, 60);
    send(0, 6'b000010, -1);
    expect_frame("err", 2, 64'h0001020304050607, 64'h08090A0B0C0D0E0F, 0, 0, 1, 0, 0);

    build(MAC, 8'd17, IP, 16'd8080, 20, 8'h10, 0);
    send(0, 6'd0, -1);
    expect_frame("flush", 3, 64'h1011121314151617, 64'h18191A1B1C1D1E1F,
                 64'h2021222300000000, 1, 0, 1, 20);

    build(MAC, 8'd17, IP, 16'd8080, 16, 8'h00, 60);
    send(3, 6'd0, -1);
    expect_frame("short", 0, 0, 0, 0, 0, 1, 0, 0);

    build(BC, 8'd17, IP, 16'd8080, 0, 8'h00, 60);
    send(0, 6'd0, -1);
    build(MAC, 8'd17, IP, 16'd8080, 16, 8'h40, 60);
    send(0, 6'd0, 3);
    expect_frame("b2b", 2, 64'h4041424344454647, 64'h48494A4B4C4D4E4F, 0, 2, 0, 1, 16);
    if (fin_cnt >= 2) check("b2b_len0", 64'(lens[fin_cnt - 2]), 64'd0);

    build(MAC, 8'd17, IP, 16'd8080, 64, 8'h00, 60);
    for (int b = 0; b < 6; b++) drive_beat(b, 1'b0, 6'd0, 1'b0);
    drive_beat(6, 1'b0, 6'd0, 1'b1);
    idle(1);
    check("rstmid_ready", 64'(ready), 64'd1);
    check("rstmid_wr_req", 64'(wr_req), 64'd0);
    expect_frame("rstmid", 0, 0, 0, 0, 0, 0, 0, 0);
    build(MAC, 8'd17, IP, 16'd8080, 16, 8'h80, 60);
    send(0, 6'd0, -1);
    expect_frame("after_rst", 2, 64'h8081828384858687, 64'h88898A8B8C8D8E8F, 0, 1, 0, 1, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_rx_parser.md
Name: udp_rx_parser

Overview:
- Receive-side counterpart of the UDP packet builder.
- Sinks the 64-bit Avalon-ST RX stream from the 10G MAC and checks the Ethernet/IPv4/UDP headers against local parameters.
- Strips the 42-byte header and re-aligns the payload onto 64-bit words.
- Writes the payload into the user RX FIFO via wr_data/wr_req, then reports frame completion or discard.

Parameters:
LOCAL_MAC, 48'h00_1C_23_17_4A_CB, accepted destination MAC (FF:FF:FF:FF:FF:FF always accepted too)
LOCAL_IP, 32'hC0A8_0002, accepted destination IPv4 address
LOCAL_PORT, 16'd8080, accepted UDP destination port

Ports:
clk_156_25  in  1  MAC/PHY clock, 156.25 MHz; sole clock
rst  in  1  synchronous reset, active-high
avalon_st_rx_startofpacket  in  1  first beat of frame
avalon_st_rx_endofpacket  in  1  last beat of frame
avalon_st_rx_valid  in  1  beat valid
avalon_st_rx_ready  out  1  sink ready
avalon_st_rx_data  in  64  frame bytes, first byte in [63:56]
avalon_st_rx_empty  in  3  unused bytes on eop beat (ignored; length taken from UDP header)
avalon_st_rx_error  in  6  MAC error flags, sampled on eop beat
wr_data  out  64  payload word, first payload byte in [63:56]
wr_req  out  1  FIFO write strobe, one word per cycle
rx_finish  out  1  one-cycle pulse: good frame fully written
rx_drop  out  1  one-cycle pulse: frame discarded or written payload invalid
rx_length  out  16  payload byte count (UDP length − 8); valid while rx_finish is high, held otherwise

Behaviour:
- Reset values: all outputs 0 except avalon_st_rx_ready = 1; state = IDLE. Reset aborts any frame in flight with no pulses and no writes.
- A beat is accepted when valid && ready. avalon_st_rx_ready = 0 only in FLUSH, otherwise 1.
- Beat index b counts accepted beats from sop (b = 0). sop in any state other than IDLE is treated as a new frame; the old frame ends silently.
- Header byte offsets: dst MAC 0–5, ethertype 12–13, ver/IHL 14, protocol 23, dst IP 30–33, dst port 36–37, UDP length 38–39, payload from 42.
  - In beat terms: payload byte 0 is beat5[47:40]; payload word n = {beat(5+n)[47:0], beat(6+n)[63:48]}.
- Filter, cumulative through beat 4. Any failure moves to DROP.
  - dst MAC = LOCAL_MAC or broadcast.
  - ethertype = 16'h0800.
  - ver/IHL = 8'h45.
  - protocol = 8'd17.
  - dst IP = LOCAL_IP.
  - dst port = LOCAL_PORT.
  - UDP length ≥ 8.
- States:
  - IDLE: wait for sop.
  - HDR: beats 0–4; checks filter; latches L = UDPlen − 8 into 16-bit bytes_left.
  - PAYLOAD: from beat 5.
  - FLUSH: one cycle.
  - DROP: wait for eop.
- PAYLOAD rules:
  - Beat 5 is loaded into the 48-bit hold register (data[47:0]); no write.
  - Each later accepted beat with bytes_left > 0 registers wr_data = {hold, data[63:48]} and asserts wr_req on the next cycle. bytes_left −= min(8, bytes_left). hold ← data[47:0].
  - Bytes of the final word beyond L are forced to 0.
  - If bytes_left reaches 0, further beats (Ethernet padding) are consumed with no writes.
- eop in PAYLOAD:
  - bytes_left = 0 after this beat's write and error = 0 → rx_finish on the cycle after eop, aligned with the last wr_req; rx_length = L. Go to IDLE.
  - 0 < bytes_left ≤ 6 and all remaining bytes lie in this beat's data[47:0] → go to FLUSH. FLUSH writes {data[47:0], 16'h0} masked to bytes_left, with rx_finish (error = 0) or rx_drop in the same cycle, then returns to IDLE.
  - Otherwise (truncated) or error ≠ 0 → rx_drop, no rx_finish. Already-written words stay in the FIFO; the consumer discards them on rx_drop.
- DROP: no writes; rx_drop on the cycle after eop; then IDLE.
- eop before beat 5 → rx_drop.
- L = 0 → no writes; rx_finish after eop.
- valid gaps (valid = 0) mid-frame: state and counters hold.
- Throughput: back-to-back frames sustained except for the single FLUSH bubble.
- No FIFO backpressure; the FIFO is sized by the integrator.

Test Plan:
- Matching frame, L = 16, payload bytes 0x00..0x0F, 60-byte frame → two wr_req: 64'h0001020304050607, then 64'h08090A0B0C0D0E0F; rx_finish with rx_length = 16; no rx_drop.
- L = 10, payload 0xA0..0xA9, padded to 60 bytes → words 64'hA0A1A2A3A4A5A6A7 and 64'hA8A9000000000000; rx_finish; rx_length = 10.
- Dst port 8081 (or protocol 6, or dst IP mismatch) → no wr_req; one rx_drop after eop.
- Matching frame, L = 16, eop beat carries error = 6'b000010 → both words written; rx_drop; no rx_finish.
- Broadcast dst MAC, L = 0, immediately followed back-to-back by a matching L = 16 frame; valid gaps inside the second frame → first frame: rx_finish, rx_length = 0, zero writes; second frame: correct two words and rx_finish.
- rst asserted for 1 cycle at beat 6 of an L = 64 frame, then a new valid frame → no pulses for the aborted frame; ready = 1; new frame parsed correctly.
